cpu_clock_sequencer: RTL

Run/halt/single-step controller for the CPU core clock. Generates a one-`clk_in`-cycle clock-enable pulse (`cpu_ce`) at a programmable divide ratio. It supports free-running, N-step bursts and breakpoint stops requested by the core. It sits between the board clock domain and every CPU pipeline register (all gated by `cpu_ce`), so the core never sees a derived clock.

---
 rtl/cpu_clock_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/cpu_clock_sequencer.sv
// Run/halt/single-step sequencer for the CPU core: emits a one-cycle clock-enable
// pulse every div_eff clk_in cycles while running or stepping.
module cpu_clock_sequencer #(
    parameter int DIV_WIDTH   = 25,
    parameter int DEFAULT_DIV = 100,
    parameter int STEP_WIDTH  = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  cfg_we,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic                  cmd_run,
    input  logic                  cmd_halt,
    input  logic                  cmd_step,
    input  logic [STEP_WIDTH-1:0] step_count,
    input  logic                  halt_req,
    output logic                  cpu_ce,
    output logic [1:0]            state,
    output logic                  busy,
    output logic [STEP_WIDTH-1:0] steps_left,
    output logic [31:0]           pulse_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ce_q, ce_d;
    logic                  busy_q, busy_d;
    logic [STEP_WIDTH-1:0] steps_q, steps_d;
    logic [31:0]           pc_q, pc_d;

    logic [DIV_WIDTH-1:0]  div_eff;
    logic                  active;
    logic                  active_d;
    logic                  tick_due;
    logic                  tick;

    always_comb begin
        div_eff  = (div_q <= DIV_WIDTH'(1)) ? DIV_WIDTH'(1) : div_q;
        active   = (state_q == ST_RUN) || (state_q == ST_STEP);
        tick_due = active && (cnt_q == div_eff - DIV_WIDTH'(1));
        // A due tick is swallowed by a halt, a breakpoint or a divider reload.
        tick     = tick_due && !cmd_halt && !halt_req && !cfg_we;

        state_d = state_q;
        if (cmd_halt) begin
            state_d = ST_IDLE;
        end else if (cmd_step) begin
            state_d = ST_STEP;
        end else if (cmd_run) begin
            state_d = ST_RUN;
        end else if (halt_req && active) begin
            state_d = ST_BREAK;
        end else if ((state_q == ST_STEP) && tick && (steps_q == STEP_WIDTH'(1))) begin
            state_d = ST_IDLE;
        end

        active_d = (state_d == ST_RUN) || (state_d == ST_STEP);
        busy_d   = active_d;

        steps_d = steps_q;
        if (cmd_halt) begin
            steps_d = '0;
        end else if (cmd_step) begin
            steps_d = (step_count == '0) ? STEP_WIDTH'(1) : step_count;
        end else if (state_d != ST_STEP) begin
            steps_d = '0;
        end else if (tick) begin
            steps_d = steps_q - STEP_WIDTH'(1);
        end

        // A new step burst always restarts the period, even when already stepping.
        if (cfg_we || cmd_step || (state_d != state_q) || !active_d || tick_due) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end

        div_d = cfg_we ? cfg_div : div_q;
        ce_d  = tick;
        pc_d  = pc_q + {31'd0, tick};
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            div_q   <= DIV_WIDTH'(DEFAULT_DIV);
            cnt_q   <= '0;
            ce_q    <= 1'b0;
            busy_q  <= 1'b0;
            steps_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            ce_q    <= ce_d;
            busy_q  <= busy_d;
            steps_q <= steps_d;
            pc_q    <= pc_d;
        end
    end

    assign cpu_ce      = ce_q;
    assign state       = state_q;
    assign busy        = busy_q;
    assign steps_left  = steps_q;
    assign pulse_count = pc_q;

endmodule
